hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Hazard control unit for the 5-stage MIPS pipeline. It reads the ID/EX pipeline register's Rt and MemRead outputs together with the IF/ID source fields, and generates the stall, bubble and flush controls that write back into the PC, IF/ID, ID/EX and EX/MEM registers. A counter-driven FSM holds load-use stalls for a configurable number of cycles. Taken branches resolved in MEM flush the pipeline and override any stall. It also keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- STALL_CYCLES, 1, number of cycles a load-use stall is held (legal 1–7)
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ID_EX_MemRead  in  1  MemRead_out of the ID/EX register
- ID_EX_Rt  in  5  Rt_out of the ID/EX register (load destination)
- IF_ID_Rs  in  5  Rs field of the instruction in IF/ID
- IF_ID_Rt  in  5  Rt field of the instruction in IF/ID
- IF_ID_UsesRt  in  1  the IF/ID instruction reads Rt (R-type, beq, sw)
- EX_MEM_BranchTaken  in  1  Branch_out & Zero from EX/MEM
- PCWrite  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  clear IF/ID to NOP
- ID_EX_Bubble  out  1  force ID/EX control inputs to zero
- EX_MEM_Flush  out  1  clear EX/MEM control bits
- stall_active  out  1  FSM is in STALL or is starting one this cycle
- stall_cnt  out  CNT_W  stall cycles since reset
- flush_cnt  out  CNT_W  branch flushes since reset

## Operation
- load_use = ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_EX_Rt == IF_ID_Rs) | (IF_ID_UsesRt & ID_EX_Rt == IF_ID_Rt)). The condition is combinational. Rt = $0 never causes a hazard.
- FSM states: IDLE and STALL. There is a down-counter `remain` of 3 bits.
- IDLE, EX_MEM_BranchTaken = 1:
  - Flush: IF_ID_Flush = 1, ID_EX_Bubble = 1, EX_MEM_Flush = 1, PCWrite = 1, IF_ID_Write = 1.
  - Stay in IDLE. flush_cnt increments by 1.
- IDLE, load_use = 1 (no branch):
  - Stall: PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, stall_active = 1. stall_cnt increments by 1.
  - If STALL_CYCLES > 1, go to STALL with remain = STALL_CYCLES-1. Otherwise stay in IDLE.
- IDLE, otherwise: PCWrite = 1, IF_ID_Write = 1, all flush and bubble outputs 0.
- STALL, no branch:
  - Same stall outputs as above. stall_cnt increments by 1. remain decrements.
  - When remain == 1, go to IDLE at the next edge.
  - load_use is ignored in STALL, because the bubble has already cleared ID/EX.
- STALL, EX_MEM_BranchTaken = 1: the flush outputs apply (branch has priority). Go to IDLE, set remain = 0, flush_cnt increments by 1, stall_cnt does not.
- Branch and load_use in the same IDLE cycle: flush only, and no stall is started.
- Counters are CNT_W bits wide and wrap modulo 2^CNT_W with no saturation.
- All control outputs are Mealy (combinational from state and inputs). stall_cnt and flush_cnt are registered.

## Timing
- While rst = 0:
  - state = IDLE, remain = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs are forced: PCWrite = 0, IF_ID_Write = 0, IF_ID_Flush = 0, ID_EX_Bubble = 1, EX_MEM_Flush = 0, stall_active = 0.
- After rst deasserts, the first rising edge is the first active cycle. Outputs follow the normal rules immediately after deassertion.
- A load-use stall asserts in the same cycle the hazard is visible, with zero latency. It lasts exactly STALL_CYCLES consecutive cycles.
- A flush is a single-cycle pulse in the cycle EX_MEM_BranchTaken is high. It repeats every cycle the input stays high.
- Counter updates become visible on the edge that ends the event cycle.
- If rst asserts mid-stall, the stall aborts immediately (asynchronously) and all registers take their reset values.

## Test plan
- Reset: hold rst = 0 for 3 cycles with random inputs. Required: PCWrite = 0, ID_EX_Bubble = 1, and both counters = 0 throughout.
- Load-use, STALL_CYCLES = 1: ID_EX_MemRead = 1, ID_EX_Rt = 8, IF_ID_Rs = 8 for one cycle, then MemRead = 0. Required: exactly 1 cycle with PCWrite = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, and stall_cnt = 1.
- $0 and unused Rt: ID_EX_Rt = 0 = IF_ID_Rs, then ID_EX_Rt = 9 = IF_ID_Rt with IF_ID_UsesRt = 0. Required: no stall and stall_cnt stays at 0.
- Multi-cycle stall, STALL_CYCLES = 3: hazard in cycle 0. Required: stall in cycles 0, 1, 2 and normal operation in cycle 3. stall_cnt = 3.
- Branch during stall, STALL_CYCLES = 3: hazard in cycle 0, EX_MEM_BranchTaken = 1 in cycle 1. Required: cycle 1 shows flush outputs with PCWrite = 1, cycle 2 is normal, stall_cnt = 1, flush_cnt = 1.
- Counter wrap, CNT_W = 4: 17 branch pulses. Required: flush_cnt = 1. Simultaneous branch and hazard in IDLE gives flush only, with no stall increment.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Load-use / branch hazard control for a 5-stage MIPS pipeline.
// Load-use stalls are held STALL_CYCLES cycles; a taken branch in MEM flushes and overrides any stall.
module hazard_stall_controller #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             EX_MEM_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       REMAIN_INI = 3'(STALL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       remain_q, remain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  // $0 is hard-wired zero, so a load into it can never create a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remain_q    <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Flush = 1'b0;
    stall_active = 1'b0;

    if (!rst) begin
      // Keep the pipeline frozen and ID/EX empty while reset is held.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (EX_MEM_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_MEM_Flush = 1'b1;
      flush_cnt_d  = flush_cnt_q + CNT_ONE;
      state_d      = IDLE;
      if (state_q == STALL) begin
        remain_d = 3'd0;
      end
    end else if ((state_q == STALL) || load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      stall_active = 1'b1;
      stall_cnt_d  = stall_cnt_q + CNT_ONE;
      if (state_q == IDLE) begin
        if (STALL_CYCLES > 1) begin
          state_d  = STALL;
          remain_d = REMAIN_INI;
        end
      end else begin
        remain_d = remain_q - 3'd1;
        if (remain_q == 3'd1) begin
          state_d = IDLE;
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Random and directed checks of two controller configurations (1-cycle/16-bit, 3-cycle/4-bit)
// against a remaining-stall-cycles reference model.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
  logic       IF_ID_UsesRt;
  logic       EX_MEM_BranchTaken;

  logic        pcw_a, ifw_a, iff_a, bub_a, emf_a, sta_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        pcw_b, ifw_b, iff_b, bub_b, emf_b, sta_b;
  logic [3:0]  scnt_b, fcnt_b;

  int checks = 0;
  int errors = 0;
  int m_rem[2];
  int m_stall[2];
  int m_flush[2];
  int m_sc[2];
  int m_cw[2];

  always #5 clk = ~clk;

  hazard_stall_controller #(.STALL_CYCLES(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .EX_MEM_BranchTaken(EX_MEM_BranchTaken), .PCWrite(pcw_a), .IF_ID_Write(ifw_a),
    .IF_ID_Flush(iff_a), .ID_EX_Bubble(bub_a), .EX_MEM_Flush(emf_a),
    .stall_active(sta_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  hazard_stall_controller #(.STALL_CYCLES(3), .CNT_W(4)) u_s3 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .EX_MEM_BranchTaken(EX_MEM_BranchTaken), .PCWrite(pcw_b), .IF_ID_Write(ifw_b),
    .IF_ID_Flush(iff_b), .ID_EX_Bubble(bub_b), .EX_MEM_Flush(emf_b),
    .stall_active(sta_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hazard();
    return ID_EX_MemRead && (ID_EX_Rt != 0) &&
           ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && ID_EX_Rt == IF_ID_Rt));
  endfunction

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush, stall_active}
  function automatic logic [5:0] exp_ctl(input int i);
    if (!rst)                           return 6'b000100;
    if (EX_MEM_BranchTaken)             return 6'b111110;
    if (m_rem[i] > 0 || hazard())       return 6'b000101;
    return 6'b110000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic lu;
    lu = hazard();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (EX_MEM_BranchTaken) begin
        m_rem[i]   = 0;
        m_flush[i] = (m_flush[i] + 1) % (1 << m_cw[i]);
      end else if (m_rem[i] > 0 || lu) begin
        m_rem[i]   = (m_rem[i] > 0) ? m_rem[i] - 1 : m_sc[i] - 1;
        m_stall[i] = (m_stall[i] + 1) % (1 << m_cw[i]);
      end
    end
  endtask

  task automatic check_now(input string tag);
    check_val({tag, " ctl_s1"}, 32'({pcw_a, ifw_a, iff_a, bub_a, emf_a, sta_a}), 32'(exp_ctl(0)));
    check_val({tag, " ctl_s3"}, 32'({pcw_b, ifw_b, iff_b, bub_b, emf_b, sta_b}), 32'(exp_ctl(1)));
    check_val({tag, " stall_cnt_s1"}, 32'(scnt_a), 32'(m_stall[0]));
    check_val({tag, " flush_cnt_s1"}, 32'(fcnt_a), 32'(m_flush[0]));
    check_val({tag, " stall_cnt_s3"}, 32'(scnt_b), 32'(m_stall[1]));
    check_val({tag, " flush_cnt_s3"}, 32'(fcnt_b), 32'(m_flush[1]));
  endtask

  // Inputs are driven 1 time unit after posedge; outputs are checked at negedge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    ID_EX_MemRead = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
    IF_ID_UsesRt = 0; EX_MEM_BranchTaken = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    #1 model_reset();
    cycle("rst");
    rst = 1'b1;
  endtask

  task automatic set_hazard(input logic [4:0] r);
    ID_EX_MemRead = 1; ID_EX_Rt = r; IF_ID_Rs = r; IF_ID_Rt = 5'd3; IF_ID_UsesRt = 0;
  endtask

  initial begin
    m_sc[0] = 1; m_sc[1] = 3;
    m_cw[0] = 16; m_cw[1] = 4;
    model_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset held 3 cycles with random inputs
    for (int k = 0; k < 3; k++) begin
      ID_EX_MemRead = 1'($urandom); ID_EX_Rt = 5'($urandom); IF_ID_Rs = 5'($urandom);
      IF_ID_Rt = 5'($urandom); IF_ID_UsesRt = 1'($urandom); EX_MEM_BranchTaken = 1'($urandom);
      cycle("reset_hold");
    end
    $display("reset hold: 3 cycles checked");
    rst = 1'b1;
    idle_inputs();

    // Single load-use hazard
    apply_reset();
    set_hazard(5'd8);
    cycle("lu_c0");
    idle_inputs();
    for (int k = 0; k < 3; k++) cycle("lu_after");
    check_val("lu stall_cnt_s1", 32'(scnt_a), 32'd1);
    check_val("lu stall_cnt_s3", 32'(scnt_b), 32'd3);
    $display("load-use: stall_cnt s1=%0d s3=%0d", scnt_a, scnt_b);

    // $0 destination and unused Rt must not stall
    apply_reset();
    ID_EX_MemRead = 1; ID_EX_Rt = 0; IF_ID_Rs = 0;
    cycle("zero_rt");
    ID_EX_Rt = 5'd9; IF_ID_Rt = 5'd9; IF_ID_Rs = 5'd1; IF_ID_UsesRt = 0;
    cycle("unused_rt");
    idle_inputs();
    check_val("norstall stall_cnt_s1", 32'(scnt_a), 32'd0);
    check_val("norstall stall_cnt_s3", 32'(scnt_b), 32'd0);
    $display("no-hazard cases: stall_cnt s1=%0d s3=%0d", scnt_a, scnt_b);

    // Rt dependency with UsesRt set
    apply_reset();
    ID_EX_MemRead = 1; ID_EX_Rt = 5'd12; IF_ID_Rt = 5'd12; IF_ID_Rs = 5'd2; IF_ID_UsesRt = 1;
    cycle("rt_dep");
    idle_inputs();
    for (int k = 0; k < 3; k++) cycle("rt_dep_after");
    check_val("rtdep stall_cnt_s3", 32'(scnt_b), 32'd3);
    $display("rt dependency: stall_cnt s3=%0d", scnt_b);

    // Branch arriving during a multi-cycle stall
    apply_reset();
    set_hazard(5'd8);
    cycle("bds_c0");
    idle_inputs();
    EX_MEM_BranchTaken = 1;
    cycle("bds_c1");
    EX_MEM_BranchTaken = 0;
    cycle("bds_c2");
    check_val("bds stall_cnt_s3", 32'(scnt_b), 32'd1);
    check_val("bds flush_cnt_s3", 32'(fcnt_b), 32'd1);
    $display("branch in stall: stall_cnt=%0d flush_cnt=%0d", scnt_b, fcnt_b);

    // 17 branch pulses with a simultaneous hazard: flush only, 4-bit counter wraps
    apply_reset();
    set_hazard(5'd5);
    EX_MEM_BranchTaken = 1;
    for (int k = 0; k < 17; k++) cycle("wrap");
    idle_inputs();
    check_val("wrap flush_cnt_s3", 32'(fcnt_b), 32'd1);
    check_val("wrap flush_cnt_s1", 32'(fcnt_a), 32'd17);
    check_val("wrap stall_cnt_s3", 32'(scnt_b), 32'd0);
    $display("wrap: flush_cnt s3=%0d s1=%0d", fcnt_b, fcnt_a);

    // Randomized traffic with occasional asynchronous reset mid-cycle
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      ID_EX_MemRead = ($urandom_range(0, 2) != 0);
      ID_EX_Rt = 5'($urandom_range(0, 3));
      IF_ID_Rs = 5'($urandom_range(0, 3));
      IF_ID_Rt = 5'($urandom_range(0, 3));
      IF_ID_UsesRt = 1'($urandom);
      EX_MEM_BranchTaken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b0;
        #1 model_reset();
      end else begin
        rst = 1'b1;
      end
      cycle("rand");
    end
    $display("random: 600 cycles checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
